branch_predictor: RTL

Dynamic branch predictor for the five-stage pipeline. It replaces static not-taken fetch with a direct-mapped branch target buffer (BTB) and per-entry saturating counters. Fetch receives a zero-latency prediction of the next PC. Execute trains the table with resolved outcomes and gets a misprediction flag and a recovery PC, which feed the hazard unit's flush and redirect logic.

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/bp_table.sv | 75 +++++++
 rtl/branch_predictor.sv | 93 +++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
// Holds the BTB entry layout, the update opcode handed to the table, the
// weak-taken / weak-not-taken counter encodings and saturating counter math.
// Storage geometry (entry widths) follows the localparams below. The top-level
// parameters default to these values and must be kept equal to them.
package bp_pkg;

  localparam int BP_DATA_W  = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX     = $clog2(BP_ENTRIES);
  localparam int BP_CTR_W   = 2;
  localparam int BP_TAG_W   = BP_DATA_W - 2 - BP_IDX;

  typedef logic [BP_CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_WEAK_T  = ctr_t'(2 ** (BP_CTR_W - 1));
  localparam ctr_t CTR_WEAK_NT = ctr_t'(2 ** (BP_CTR_W - 1) - 1);
  localparam ctr_t CTR_MAX     = '1;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_DATA_W-1:0] target;
    logic                 jump;
    ctr_t                 ctr;
  } bp_entry_t;

  // Update request sent from execute to the table.
  typedef enum logic [1:0] {
    BP_OP_NONE      = 2'd0,
    BP_OP_TAKEN     = 2'd1,
    BP_OP_NOT_TAKEN = 2'd2
  } bp_op_e;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_MAX) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset (clears valid, ctr -> weak NT)
//   ridx_i / rdata_o   combinational read port (fetch lookup)
//   op_i, widx_i,      synchronous write port; the table itself resolves
//   wtag_i, wtarget_i, hit/miss on the write index so that the update side
//   wjump_i            needs no second read port
// A same-cycle read of the written index returns the pre-edge contents.
module bp_table
  import bp_pkg::*;
#(
  parameter  int ENTRIES = BP_ENTRIES,
  localparam int IDX     = $clog2(ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IDX-1:0]       ridx_i,
  output bp_entry_t            rdata_o,
  input  bp_op_e               op_i,
  input  logic [IDX-1:0]       widx_i,
  input  logic [BP_TAG_W-1:0]  wtag_i,
  input  logic [BP_DATA_W-1:0] wtarget_i,
  input  logic                 wjump_i
);

  logic                 valid_q  [ENTRIES];
  ctr_t                 ctr_q    [ENTRIES];
  logic [BP_TAG_W-1:0]  tag_q    [ENTRIES];
  logic [BP_DATA_W-1:0] target_q [ENTRIES];
  logic                 jump_q   [ENTRIES];

  logic whit;

  always_comb begin
    rdata_o        = '0;
    rdata_o.valid  = valid_q[ridx_i];
    rdata_o.tag    = tag_q[ridx_i];
    rdata_o.target = target_q[ridx_i];
    rdata_o.jump   = jump_q[ridx_i];
    rdata_o.ctr    = ctr_q[ridx_i];
  end

  assign whit = valid_q[widx_i] && (tag_q[widx_i] == wtag_i);

  // Valid and counter state: async reset, so a reset mid-update wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else begin
      case (op_i)
        BP_OP_TAKEN: begin
          valid_q[widx_i] <= 1'b1;
          ctr_q[widx_i]   <= whit ? ctr_inc(ctr_q[widx_i]) : CTR_WEAK_T;
        end
        BP_OP_NOT_TAKEN: begin
          if (whit) ctr_q[widx_i] <= ctr_dec(ctr_q[widx_i]);
        end
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: valid gates every use of it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && op_i == BP_OP_TAKEN) begin
      tag_q[widx_i]    <= wtag_i;
      target_q[widx_i] <= wtarget_i;
      jump_q[widx_i]   <= wjump_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating counters.
// Ports:
//   clk, rst                         clock, async active-low reset
//   pcF, lookup_validF               fetch PC, fetch-advancing strobe (stats only)
//   predict_takenF, predict_targetF  zero-latency prediction of next PC
//   update_validE, pcE, takenE,      resolved branch/jump from execute
//   is_jumpE, targetE
//   pred_takenE, pred_targetE        prediction that was made in fetch
//   mispredictE, recover_pcE         redirect request and correct next PC
//   lookup_cnt, mispredict_cnt       wrapping performance counters
module branch_predictor
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH = BP_DATA_W,
  parameter int ENTRIES    = BP_ENTRIES,
  parameter int CTR_WIDTH  = BP_CTR_W,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pcF,
  input  logic                  lookup_validF,
  output logic                  predict_takenF,
  output logic [DATA_WIDTH-1:0] predict_targetF,
  input  logic                  update_validE,
  input  logic [DATA_WIDTH-1:0] pcE,
  input  logic                  takenE,
  input  logic                  is_jumpE,
  input  logic [DATA_WIDTH-1:0] targetE,
  input  logic                  pred_takenE,
  input  logic [DATA_WIDTH-1:0] pred_targetE,
  output logic                  mispredictE,
  output logic [DATA_WIDTH-1:0] recover_pcE,
  output logic [STAT_WIDTH-1:0] lookup_cnt,
  output logic [STAT_WIDTH-1:0] mispredict_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - 2 - IDX;

  bp_entry_t rd;
  bp_op_e    op;
  logic      hitF;

  logic [STAT_WIDTH-1:0] lookup_cnt_q, lookup_cnt_d;
  logic [STAT_WIDTH-1:0] misp_cnt_q, misp_cnt_d;

  bp_table #(.ENTRIES(ENTRIES)) u_table (
    .clk_i     (clk),
    .rst_ni    (rst),
    .ridx_i    (pcF[IDX+1:2]),
    .rdata_o   (rd),
    .op_i      (op),
    .widx_i    (pcE[IDX+1:2]),
    .wtag_i    (pcE[DATA_WIDTH-1:IDX+2]),
    .wtarget_i (targetE),
    .wjump_i   (is_jumpE)
  );

  // Lookup: the jump bit overrides the direction counter.
  assign hitF            = rd.valid && (rd.tag == pcF[DATA_WIDTH-1:DATA_WIDTH-TAG_W]);
  assign predict_takenF  = hitF && (rd.jump || rd.ctr[CTR_WIDTH-1]);
  assign predict_targetF = predict_takenF ? rd.target : pcF + DATA_WIDTH'(4);

  // A correct direction with a wrong target still needs a redirect when taken.
  assign mispredictE = update_validE &&
                       ((takenE != pred_takenE) || (takenE && (targetE != pred_targetE)));
  assign recover_pcE = takenE ? targetE : pcE + DATA_WIDTH'(4);

  always_comb begin
    op = BP_OP_NONE;
    if (update_validE) op = takenE ? BP_OP_TAKEN : BP_OP_NOT_TAKEN;
  end

  always_comb begin
    lookup_cnt_d = lookup_cnt_q + STAT_WIDTH'(lookup_validF);
    misp_cnt_d   = misp_cnt_q + STAT_WIDTH'(mispredictE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lookup_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      lookup_cnt_q <= lookup_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign lookup_cnt     = lookup_cnt_q;
  assign mispredict_cnt = misp_cnt_q;

endmodule
